// File: rtl/cic_pkg.sv
// rtl/cic_pkg.sv - shared state encoding and drop-counter helpers for the CIC decimator controller
package cic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_WARMUP = 2'd2,
    ST_RUN    = 2'd3
  } cic_state_e;

  localparam int DROP_W = 16;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cic_decim_ctrl_if.sv
// rtl/cic_decim_ctrl_if.sv - control/status bundle around one cic_decim_ctrl instance
interface cic_decim_ctrl_if #(
  parameter int RATE_W = 16
) ();
  import cic_pkg::*;

  logic              enable;
  logic [RATE_W-1:0] rate;
  logic              rate_load;
  logic              valid;
  logic              clear;
  logic              integ_valid;
  logic              comb_valid;
  logic              out_valid;
  logic [1:0]        state;
  logic [DROP_W-1:0] drop_count;

  modport master (
    output enable, rate, rate_load, valid,
    input  clear, integ_valid, comb_valid, out_valid, state, drop_count
  );

  modport slave (
    input  enable, rate, rate_load, valid,
    output clear, integ_valid, comb_valid, out_valid, state, drop_count
  );

endinterface

// File: rtl/cic_rate_counter.sv
// rtl/cic_rate_counter.sv - counts accepted samples modulo the active rate and emits a registered comb strobe
// reset is active-low and asynchronous; clear drops both the count and any pending strobe.
module cic_rate_counter #(
  parameter int RATE_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              i_valid,
  input  logic [RATE_W-1:0] rate,
  output logic              o_strobe
);

  logic [RATE_W-1:0] cnt_q, cnt_d;
  logic              strobe_q, strobe_d;

  always_comb begin
    cnt_d    = cnt_q;
    strobe_d = 1'b0;
    if (clear) begin
      cnt_d = '0;
    end else if (i_valid) begin
      if (cnt_q >= rate - 1'b1) begin
        cnt_d    = '0;
        strobe_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q    <= '0;
      strobe_q <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      strobe_q <= strobe_d;
    end
  end

  assign o_strobe = strobe_q;

endmodule

// File: rtl/cic_decim_ctrl.sv
// rtl/cic_decim_ctrl.sv - sequences flush, warm-up and run phases of a CIC decimator datapath
module cic_decim_ctrl
  import cic_pkg::*;
#(
  parameter int RATE_W       = 16,
  parameter int STAGES       = 4,
  parameter int DELAY        = 2,
  parameter int FLUSH_CYCLES = 4
) (
  input  logic              i_clock,
  input  logic              i_reset_n,
  input  logic              i_enable,
  input  logic [RATE_W-1:0] i_rate,
  input  logic              i_rate_load,
  input  logic              i_valid,
  output logic              o_clear,
  output logic              o_integ_valid,
  output logic              o_comb_valid,
  output logic              o_out_valid,
  output logic [1:0]        o_state,
  output logic [DROP_W-1:0] o_drop_count
);

  localparam int WARM_N = STAGES * DELAY;
  localparam int FL_W   = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;
  localparam int WM_W   = (WARM_N > 1) ? $clog2(WARM_N) : 1;

  cic_state_e        state_q, state_d;
  logic [FL_W-1:0]   flush_q, flush_d;
  logic [WM_W-1:0]   warm_q, warm_d;
  logic [RATE_W-1:0] rate_q, rate_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic              accept;
  logic              ctr_clear;
  logic              comb_strobe;

  assign accept = i_valid && (state_q == ST_WARMUP || state_q == ST_RUN);

  always_comb begin
    state_d = state_q;
    flush_d = '0;
    warm_d  = '0;
    rate_d  = rate_q;
    drop_d  = drop_q;
    if (i_rate_load) rate_d = (i_rate == '0) ? RATE_W'(1) : i_rate;
    if (state_q == ST_FLUSH && i_valid) drop_d = sat_inc(drop_q);
    case (state_q)
      ST_IDLE: state_d = ST_FLUSH;
      ST_FLUSH: begin
        if (flush_q == FL_W'(FLUSH_CYCLES - 1)) state_d = ST_WARMUP;
        else flush_d = flush_q + 1'b1;
      end
      ST_WARMUP: begin
        if (i_rate_load) begin
          state_d = ST_FLUSH;
        end else begin
          // Strobes seen here only settle the comb pipeline; none reach o_out_valid.
          warm_d = warm_q + WM_W'(comb_strobe);
          if (comb_strobe && warm_q == WM_W'(WARM_N - 1)) state_d = ST_RUN;
        end
      end
      ST_RUN: if (i_rate_load) state_d = ST_FLUSH;
      default: state_d = ST_IDLE;
    endcase
    if (!i_enable) state_d = ST_IDLE;
  end

  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= ST_IDLE;
      flush_q <= '0;
      warm_q  <= '0;
      rate_q  <= RATE_W'(1);
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      flush_q <= flush_d;
      warm_q  <= warm_d;
      rate_q  <= rate_d;
      drop_q  <= drop_d;
    end
  end

  // Clearing on the next state kills a strobe that would land as FLUSH/IDLE begins.
  assign ctr_clear = (state_d == ST_IDLE) || (state_d == ST_FLUSH);

  cic_rate_counter #(.RATE_W(RATE_W)) u_rate_counter (
    .clock    (i_clock),
    .reset    (i_reset_n),
    .clear    (ctr_clear),
    .i_valid  (accept),
    .rate     (rate_q),
    .o_strobe (comb_strobe)
  );

  assign o_clear       = (state_q == ST_FLUSH);
  assign o_integ_valid = accept;
  assign o_comb_valid  = comb_strobe;
  assign o_out_valid   = comb_strobe && (state_q == ST_RUN);
  assign o_state       = state_q;
  assign o_drop_count  = drop_q;

endmodule

// File: tb/tb_cic_decim_ctrl.sv
// tb/tb_cic_decim_ctrl.sv - randomized and directed checks of cic_decim_ctrl against a cycle model
module tb_cic_decim_ctrl;

  localparam int STAGES = 4;
  localparam int DELAY  = 2;
  localparam int FLUSH  = 4;
  localparam int SAT_FLUSH = 70000;

  logic clk = 1'b0;
  logic rst_n;
  logic rst2_n;
  always #5 clk = ~clk;

  cic_decim_ctrl_if #(.RATE_W(16)) bus ();
  cic_decim_ctrl_if #(.RATE_W(16)) bus2 ();

  cic_decim_ctrl #(.RATE_W(16), .STAGES(STAGES), .DELAY(DELAY), .FLUSH_CYCLES(FLUSH)) dut (
    .i_clock(clk), .i_reset_n(rst_n), .i_enable(bus.enable), .i_rate(bus.rate),
    .i_rate_load(bus.rate_load), .i_valid(bus.valid), .o_clear(bus.clear),
    .o_integ_valid(bus.integ_valid), .o_comb_valid(bus.comb_valid),
    .o_out_valid(bus.out_valid), .o_state(bus.state), .o_drop_count(bus.drop_count)
  );

  cic_decim_ctrl #(.RATE_W(16), .STAGES(STAGES), .DELAY(DELAY), .FLUSH_CYCLES(SAT_FLUSH)) dut_sat (
    .i_clock(clk), .i_reset_n(rst2_n), .i_enable(bus2.enable), .i_rate(bus2.rate),
    .i_rate_load(bus2.rate_load), .i_valid(bus2.valid), .o_clear(bus2.clear),
    .o_integ_valid(bus2.integ_valid), .o_comb_valid(bus2.comb_valid),
    .o_out_valid(bus2.out_valid), .o_state(bus2.state), .o_drop_count(bus2.drop_count)
  );

  int n_chk = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: phase, cycles spent flushing, samples since last strobe,
  // warm-up strobes seen, active R, visible strobe and drop total.
  int m_mode, m_fl, m_acc, m_warm, m_rate, m_comb, m_drop;
  int n_clear, n_comb, n_out, n_integ;

  task automatic model_reset();
    m_mode = 0; m_fl = 0; m_acc = 0; m_warm = 0; m_rate = 1; m_comb = 0; m_drop = 0;
  endtask

  task automatic model_advance(input logic en, input logic rl, input int rt, input logic v);
    int nm;
    int nc;
    if (!en) nm = 0;
    else begin
      case (m_mode)
        0: nm = 1;
        1: nm = (m_fl + 1 >= FLUSH) ? 2 : 1;
        2: nm = rl ? 1 : ((m_comb == 1 && m_warm + 1 == STAGES * DELAY) ? 3 : 2);
        default: nm = rl ? 1 : 3;
      endcase
    end
    nc = 0;
    if (nm <= 1) m_acc = 0;
    else if (m_mode >= 2 && v) begin
      m_acc++;
      if (m_acc >= m_rate) begin
        m_acc = 0;
        nc = 1;
      end
    end
    m_warm = (nm == 2 && m_mode == 2) ? m_warm + m_comb : 0;
    m_fl   = (nm == 1 && m_mode == 1) ? m_fl + 1 : 0;
    if (m_mode == 1 && v && m_drop < 65535) m_drop++;
    if (rl) m_rate = (rt == 0) ? 1 : rt;
    m_comb = nc;
    m_mode = nm;
  endtask

  task automatic step(input logic en, input logic rl, input logic [15:0] rt, input logic v);
    @(negedge clk);
    bus.enable = en; bus.rate_load = rl; bus.rate = rt; bus.valid = v;
    #1;
    chk("state", 32'(bus.state), 32'(m_mode));
    chk("clear", 32'(bus.clear), 32'(m_mode == 1));
    chk("integ", 32'(bus.integ_valid), 32'(v && m_mode >= 2));
    chk("comb", 32'(bus.comb_valid), 32'(m_comb));
    chk("out", 32'(bus.out_valid), 32'(m_comb == 1 && m_mode == 3));
    chk("drop", 32'(bus.drop_count), 32'(m_drop));
    if (bus.clear) n_clear++;
    if (bus.comb_valid) n_comb++;
    if (bus.out_valid) n_out++;
    if (bus.integ_valid) n_integ++;
    model_advance(en, rl, int'(rt), v);
  endtask

  task automatic run_until_out(input string tag, input int maxc);
    bit seen = 0;
    for (int i = 0; i < maxc && !seen; i++) begin
      step(1, 0, 0, 1);
      if (bus.out_valid) seen = 1;
    end
    if (!seen) chk(tag, 0, 1);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_state"}, 32'(bus.state), 0);
    chk({tag, "_clear"}, 32'(bus.clear), 0);
    chk({tag, "_integ"}, 32'(bus.integ_valid), 0);
    chk({tag, "_comb"}, 32'(bus.comb_valid), 0);
    chk({tag, "_out"}, 32'(bus.out_valid), 0);
    chk({tag, "_drop"}, 32'(bus.drop_count), 0);
  endtask

  task automatic main_test();
    logic [15:0] d0, d1;
    int last;
    rst_n = 1'b0;
    bus.enable = 0; bus.rate_load = 0; bus.rate = 0; bus.valid = 1;
    model_reset();
    #3;
    check_all_zero("rst");
    @(negedge clk);
    rst_n = 1'b1;

    // R=4 from power-up: 4 clear cycles, 8 silent warm-up strobes, then every 4th cycle
    step(0, 1, 4, 0);
    n_clear = 0; n_comb = 0; n_out = 0;
    for (int i = 0; i < 40; i++) step(1, 0, 0, 1);
    chk("a_clear_cycles", 32'(n_clear), 4);
    chk("a_warm_combs", 32'(n_comb), 8);
    chk("a_warm_no_out", 32'(n_out), 0);
    chk("a_in_run", 32'(bus.state), 3);
    n_out = 0; last = -1;
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 0, 1);
      if (bus.out_valid) begin
        if (last >= 0) chk("a_out_gap", 32'(i - last), 4);
        last = i;
      end
    end
    chk("a_out_count", 32'(n_out), 4);

    // rate 0 loaded in RUN becomes R=1
    step(1, 1, 0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, 0, 1);
    n_comb = 0; n_out = 0;
    for (int i = 0; i < 10; i++) step(1, 0, 0, 1);
    chk("b_comb_every", 32'(n_comb), 10);
    chk("b_out_every", 32'(n_out), 10);

    // three samples dropped during a re-flush, none integrated
    step(1, 1, 4, 0);
    d0 = bus.drop_count;
    n_integ = 0;
    step(1, 0, 0, 1); step(1, 0, 0, 1); step(1, 0, 0, 0); step(1, 0, 0, 1);
    chk("c_no_integ", 32'(n_integ), 0);
    step(1, 0, 0, 0);
    d1 = bus.drop_count;
    chk("c_drop_delta", 32'(d1 - d0), 3);

    // disable and rate load together, coinciding with the R-th sample
    run_until_out("d_first_out_timeout", 200);
    step(1, 0, 0, 1); step(1, 0, 0, 1);
    step(0, 1, 2, 1);
    step(1, 0, 0, 0);
    chk("d_idle", 32'(bus.state), 0);
    chk("d_no_comb", 32'(bus.comb_valid), 0);
    run_until_out("d_rate2_timeout", 200);
    n_out = 0;
    for (int i = 0; i < 8; i++) step(1, 0, 0, 1);
    chk("d_rate2_outs", 32'(n_out), 4);

    // asynchronous reset between edges while running
    step(1, 0, 0, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("e_rst");
    model_reset();
    @(negedge clk);
    bus.enable = 1; bus.rate_load = 0; bus.valid = 0;
    rst_n = 1'b1;
    #1;
    chk("e_rel_idle", 32'(bus.state), 0);
    model_advance(1, 0, 0, 0);
    step(1, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      step(($urandom % 50) != 0, ($urandom % 40) == 0,
           16'($urandom % 6), ($urandom % 4) != 0);
    end
  endtask

  task automatic sat_test();
    int exp;
    rst2_n = 1'b0;
    bus2.enable = 0; bus2.rate_load = 0; bus2.rate = 0; bus2.valid = 0;
    @(negedge clk);
    @(negedge clk);
    rst2_n = 1'b1;
    bus2.enable = 1;
    @(negedge clk);
    #1;
    chk("s_in_flush", 32'(bus2.state), 1);
    bus2.valid = 1;
    for (int i = 1; i <= 70000; i++) begin
      @(negedge clk);
      #1;
      if (i == 1 || i == 65534 || i == 65535 || i == 65536 || i == 70000) begin
        exp = (i < 65535) ? i : 65535;
        chk("s_drop", 32'(bus2.drop_count), 32'(exp));
      end
      if (i == 69999) chk("s_still_flush", 32'(bus2.state), 1);
      if (i == 70000) chk("s_warmup", 32'(bus2.state), 2);
    end
    bus2.valid = 0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    fork
      main_test();
      sat_test();
    join
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/cic_decim_ctrl.md
CIC_DECIM_CTRL -- requirements
Module: cic_decim_ctrl

Interface
REQ-001 SHALL have parameter RATE_W, default 16: width of decimation-rate field.
REQ-002 SHALL have parameter STAGES, default 4: number of integrator/comb stage pairs sequenced.
REQ-003 SHALL have parameter DELAY, default 2: comb differential delay.
REQ-004 SHALL have parameter FLUSH_CYCLES, default 4: length of datapath clear pulse.
REQ-005 SHALL have port i_clock, input, 1: single clock; all logic rising-edge.
REQ-006 SHALL have port i_reset_n, input, 1: asynchronous, active-low reset.
REQ-007 SHALL have port i_enable, input, 1: level; 1 = decimator running.
REQ-008 SHALL have port i_rate, input, RATE_W: requested decimation ratio R.
REQ-009 SHALL have port i_rate_load, input, 1: single-cycle pulse; latch i_rate.
REQ-010 SHALL have port i_valid, input, 1: input sample strobe.
REQ-011 SHALL have port o_clear, output, 1: synchronous clear to integrator/comb datapath.
REQ-012 SHALL have port o_integ_valid, output, 1: integrator advance strobe.
REQ-013 SHALL have port o_comb_valid, output, 1: comb advance strobe, one per R accepted samples.
REQ-014 SHALL have port o_out_valid, output, 1: decimated output is valid.
REQ-015 SHALL have port o_state, output, 2: current FSM state encoding.
REQ-016 SHALL have port o_drop_count, output, 16: samples discarded while not accepting.

Function
REQ-017 SHALL implement FSM states IDLE=0, FLUSH=1, WARMUP=2, RUN=3.
REQ-018 SHALL, from IDLE, move to FLUSH on the first cycle i_enable=1.
REQ-019 SHALL hold FLUSH for exactly FLUSH_CYCLES cycles with o_clear=1, then enter WARMUP.
REQ-020 SHALL, in WARMUP or RUN, re-enter FLUSH on i_rate_load=1, restarting the flush count.
REQ-021 SHALL, in any state, go to IDLE the cycle after i_enable=0; i_enable=0 has priority over i_rate_load.
REQ-022 SHALL latch i_rate into the active-rate register on any i_rate_load, in any state; latched value 0 is stored as 1.
REQ-023 SHALL drive o_integ_valid = i_valid combinationally only in WARMUP and RUN; otherwise 0.
REQ-024 SHALL count accepted samples 0..R-1, wrapping to 0 on the R-th; counter cleared in IDLE and FLUSH.
REQ-025 SHALL assert o_comb_valid, registered, for one cycle following the clock edge that accepts the R-th sample; R=1 gives o_comb_valid every cycle after an accepted sample.
REQ-026 SHALL count comb strobes in WARMUP; after STAGES*DELAY strobes, enter RUN; the warmup strobes, including the final one, SHALL NOT raise o_out_valid.
REQ-027 SHALL assert o_out_valid = o_comb_valid only while in RUN.
REQ-028 SHALL increment o_drop_count for each i_valid=1 in FLUSH, saturating at 16'hFFFF; never cleared except by reset.
REQ-029 SHALL ignore i_valid in IDLE without counting drops.
REQ-030 SHALL suppress a pending o_comb_valid when FLUSH or IDLE is entered in the same cycle.

Reset
REQ-031 SHALL, on i_reset_n=0, immediately force IDLE, active rate=1, all counters=0, all outputs 0.
REQ-032 SHALL, on reset release with i_enable=1, enter FLUSH on the first rising edge.
REQ-033 SHALL abandon any operation in progress when reset asserts mid-FLUSH, mid-WARMUP or mid-RUN.

Structure
REQ-034 SHALL take the state enum, state encodings and drop-counter width from shared package cic_pkg.
REQ-035 SHALL place the sample counter and comb-strobe generation in sub-module cic_rate_counter, with ports clock, reset, clear, i_valid, rate, o_strobe.
REQ-036 SHALL be 120-400 lines of RTL in total, with no multi-clock logic.

Verification
REQ-037 SHALL test R=4, STAGES=4, DELAY=2, continuous i_valid: o_clear for 4 cycles, then 8 o_comb_valid with no o_out_valid, then o_out_valid every 4th cycle.
REQ-038 SHALL test i_rate_load with i_rate=0 in RUN: re-flush occurs, active R=1, and o_comb_valid follows every accepted sample after warmup.
REQ-039 SHALL test 3 i_valid pulses during FLUSH: o_drop_count=3, with no o_integ_valid.
REQ-040 SHALL test i_enable=0 and i_rate_load asserted in the same cycle: state IDLE next cycle, new rate latched, and no o_comb_valid.
REQ-041 SHALL test i_reset_n=0 mid-RUN between clock edges: outputs 0 immediately, o_state=0.
REQ-042 SHALL test 70000 i_valid pulses in FLUSH, with FLUSH_CYCLES overridden: o_drop_count holds at 16'hFFFF.
